fpr_cdb_arbiter: RTL
====================

FPR_CDB_ARBITER -- requirements
Module: fpr_cdb_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of FPR-producing units sharing the FPR CDB (range 2..8).
REQ-002 Parameter ROB_WIDTH, default taken from common.vh, width of CDB tag.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  N_REQ  unit i wants to dispatch and write the CDB next cycle (cdb req_if valid).
REQ-006 req_ready  output  N_REQ  grant to unit i this cycle (cdb req_if ready); combinational from req_valid, cdb_block and pointer.
REQ-007 res_tag  input  N_REQ x ROB_WIDTH  registered result tag of unit i, valid the cycle after its grant.
REQ-008 res_data  input  N_REQ x 32  registered result data of unit i, valid the cycle after its grant.
REQ-009 cdb_block  input  1  slot reserved by a fixed-latency unit; no grant issued this cycle.
REQ-010 fpr_cdb  output  cdb_t (valid, tag, data)  broadcast to reservation stations, ROB and FPR file.

Function
REQ-011 At most one req_ready bit SHALL be high per cycle; req_ready[i] only when req_valid[i]=1 and cdb_block=0.
REQ-012 With any req_valid high and cdb_block=0, exactly one grant SHALL be issued (work-conserving).
REQ-013 Grant SHALL be registered as gnt_valid and gnt_idx at posedge clk.
REQ-014 Cycle after a grant: fpr_cdb.valid=1, fpr_cdb.tag=res_tag[gnt_idx], fpr_cdb.data=res_data[gnt_idx] (combinational mux on registered index); latency request-to-broadcast exactly 1 cycle.
REQ-015 Cycle with no registered grant: fpr_cdb.valid=0, tag and data don't-care (x permitted).
REQ-016 Back-to-back grants SHALL be allowed every cycle; throughput one broadcast per cycle.
REQ-017 Priority pointer ptr (clog2(N_REQ) bits) SHALL advance to (granted index + 1) mod N_REQ only on a grant; wraps N_REQ-1 -> 0.
REQ-018 Search order SHALL be ptr, ptr+1, ..., ptr+N_REQ-1 modulo N_REQ.
REQ-019 cdb_block=1 SHALL suppress all grants and leave ptr unchanged; a grant registered the previous cycle still broadcasts.
REQ-020 req_valid withdrawn without grant SHALL carry no penalty; arbiter keeps no per-requester history other than ptr.

Reset
REQ-021 On reset: gnt_valid=0, gnt_idx=0, ptr=0; fpr_cdb.valid=0 in the cycle after reset is sampled.
REQ-022 While reset=1, req_ready SHALL be all zero.
REQ-023 Reset asserted the cycle after a grant SHALL drop that pending broadcast (fpr_cdb.valid=0 next cycle).

Configuration
REQ-024 Macro FPR_CDB_RR_EN defined: round-robin arbitration per REQ-017/018.
REQ-025 FPR_CDB_RR_EN undefined: fixed priority, lowest index wins; ptr absent (treated as constant 0); all other behaviour identical.

Verification
REQ-026 Reset, then req_valid=4'b0000 for 3 cycles -> req_ready=0, fpr_cdb.valid=0 every cycle.
REQ-027 RR, ptr=0, req_valid=4'b1111 held 8 cycles -> grants 0,1,2,3,0,1,2,3; each broadcast one cycle later with matching res_tag/res_data.
REQ-028 RR, ptr=3, req_valid=4'b0101 -> grant 0 (wrap), ptr=1; next cycle grant 2, ptr=3.
REQ-029 req_valid=4'b0010 with cdb_block=1 for 2 cycles, then 0 -> no grant during block, ptr unchanged, grant 1 on third cycle, fpr_cdb.valid=1 on fourth.
REQ-030 Grant to unit 2 at cycle n, reset=1 at cycle n+1 -> fpr_cdb.valid=0 at n+1 onward, ptr=0.
REQ-031 FPR_CDB_RR_EN undefined, req_valid=4'b1100 held 3 cycles -> unit 2 granted every cycle, unit 3 never.

Source files
------------

// File: rtl/fpr_cdb_arbiter.sv
// FPR common-data-bus arbiter: grants one producer per cycle and broadcasts its result the next cycle.
// Define FPR_CDB_RR_EN for round-robin arbitration; without it, fixed priority (lowest index wins).
module fpr_cdb_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned ROB_WIDTH = 6
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_REQ-1:0]                req_valid,
    output logic [N_REQ-1:0]                req_ready,
    input  logic [N_REQ-1:0][ROB_WIDTH-1:0] res_tag,
    input  logic [N_REQ-1:0][31:0]          res_data,
    input  logic                            cdb_block,
    output logic                            fpr_cdb_valid,
    output logic [ROB_WIDTH-1:0]            fpr_cdb_tag,
    output logic [31:0]                     fpr_cdb_data
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic             r_gnt_valid;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [IDX_W-1:0] w_ptr;
    logic             w_gnt_any;
    logic [IDX_W-1:0] w_gnt_idx;
    logic [IDX_W-1:0] w_cand;

`ifdef FPR_CDB_RR_EN
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;

    // Pointer moves just past the winner, only when a grant is issued.
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_gnt_any) begin
            w_ptr_nxt = (32'(w_gnt_idx) == N_REQ - 1) ? '0 : w_gnt_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    // Search ptr, ptr+1, ... modulo N_REQ; reset and a reserved slot suppress every grant.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_cand = IDX_W'((32'(w_ptr) + k) % N_REQ);
            if (!w_gnt_any && req_valid[w_cand]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
        if (reset || cdb_block) begin
            w_gnt_any = 1'b0;
            w_gnt_idx = '0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_gnt_any) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt_valid <= 1'b0;
            r_gnt_idx   <= '0;
        end else begin
            r_gnt_valid <= w_gnt_any;
            if (w_gnt_any) begin
                r_gnt_idx <= w_gnt_idx;
            end
        end
    end

    // Producers hold their result registers during the broadcast cycle, so a plain mux suffices.
    assign fpr_cdb_valid = r_gnt_valid & ~reset;
    assign fpr_cdb_tag   = res_tag[r_gnt_idx];
    assign fpr_cdb_data  = res_data[r_gnt_idx];

endmodule
